dw_update_gen: RTL and testbench

DW_UPDATE_GEN -- requirements
Module: dw_update_gen

---
 rtl/dw_update_gen.sv | 133 +++++++++++++
 tb/tb_dw_update_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dw_update_gen.sv
// Purpose: delta-weight generator, dw = -(ETA * (delta * act)) in signed Q6.10, plus a weight-init strobe.
// Latency: start accepted at edge N -> dw_out/select_update valid N+3..N+4; one result per 4 cycles.
// Backpressure: none; start/load_init are sampled only in IDLE and dropped while busy. Option: DW_SAT_EN.
module dw_update_gen #(
  parameter logic signed [15:0] ETA = 16'sh0100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               load_init,
  input  logic signed [15:0] delta_in,
  input  logic signed [15:0] act_in,
  output logic signed [15:0] dw_out,
  output logic               select_update,
  output logic               select_initial,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL1 = 2'd1,
    MUL2 = 2'd2,
    NEG  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic signed [15:0] delta_r;
  logic signed [15:0] act_r;
  logic signed [15:0] p1_r;
  logic signed [15:0] p2_r;
  logic signed [31:0] prod1;
  logic signed [31:0] prod2;
  logic               capture;
  logic               init_pulse;

  // Reduce a Q12.20 product to Q6.10 with floor rounding (arithmetic shift by 10).
  // Saturating build clamps out-of-range values; default build keeps bits [25:10].
  function automatic logic signed [15:0] reduce_q(input logic signed [31:0] p);
    logic signed [31:0] s;
    s = p >>> 10;
`ifdef DW_SAT_EN
    if (s > 32'sd32767) begin
      return 16'sh7FFF;
    end else if (s < -32'sd32768) begin
      return 16'sh8000;
    end else begin
      return s[15:0];
    end
`else
    return s[15:0];
`endif
  endfunction

  // Negate in Q6.10; only the most negative code can overflow.
  function automatic logic signed [15:0] neg_q(input logic signed [15:0] v);
`ifdef DW_SAT_EN
    if (v == 16'sh8000) begin
      return 16'sh7FFF;
    end else begin
      return -v;
    end
`else
    return -v;
`endif
  endfunction

  // Full-width signed products feeding the two multiply stages.
  assign prod1 = 32'(delta_r) * 32'(act_r);
  assign prod2 = 32'(ETA) * 32'(p1_r);
  assign busy  = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; load_init has priority over start, both only seen in IDLE.
  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    init_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (load_init) begin
          init_pulse = 1'b1;
        end else if (start) begin
          capture   = 1'b1;
          state_nxt = MUL1;
        end
      end
      MUL1:    state_nxt = MUL2;
      MUL2:    state_nxt = NEG;
      NEG:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, two reduce stages, registered negated result and strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      delta_r        <= '0;
      act_r          <= '0;
      p1_r           <= '0;
      p2_r           <= '0;
      dw_out         <= '0;
      select_update  <= 1'b0;
      select_initial <= 1'b0;
    end else begin
      if (capture) begin
        delta_r <= delta_in;
        act_r   <= act_in;
      end
      if (state == MUL1) begin
        p1_r <= reduce_q(prod1);
      end
      if (state == MUL2) begin
        p2_r <= reduce_q(prod2);
      end
      if (state == NEG) begin
        dw_out <= neg_q(p2_r);
      end
      select_update  <= (state == NEG);
      select_initial <= init_pulse;
    end
  end

endmodule

// File: tb/tb_dw_update_gen.sv
// Purpose: self-checking bench for dw_update_gen against a real-arithmetic reference model.
// Latency: drives inputs 1 time unit after each rising edge and samples outputs there.
// Backpressure: exercises ignored start/load_init while busy and back-to-back starts.
module tb_dw_update_gen;

  localparam logic signed [15:0] ETA_V = 16'sh0200;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               load_init;
  logic signed [15:0] delta_in;
  logic signed [15:0] act_in;
  logic signed [15:0] dw_out;
  logic               select_update;
  logic               select_initial;
  logic               busy;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_dw;
  logic [15:0] exp_q[$];

  dw_update_gen #(.ETA(ETA_V)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .load_init      (load_init),
    .delta_in       (delta_in),
    .act_in         (act_in),
    .dw_out         (dw_out),
    .select_update  (select_update),
    .select_initial (select_initial),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Fit a real value (in units of one Q6.10 LSB) to 16 bits: floor, then clamp or wrap.
  function automatic int fitq(input real x);
    longint q;
    q = longint'($floor(x));
`ifdef DW_SAT_EN
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
`else
    q = q & 64'hFFFF;
    if (q >= 32768) q = q - 65536;
`endif
    return int'(q);
  endfunction

  // Reference: value-level evaluation of -(ETA * (delta * act)) with a Q6.10 fit after each step.
  function automatic logic [15:0] model_dw(input logic [15:0] d, input logic [15:0] a);
    int di;
    int ai;
    int p1;
    int p2;
    int n;
    di = $signed(d);
    ai = $signed(a);
    p1 = fitq((real'(di) * real'(ai)) / 1024.0);
    p2 = fitq((real'(ETA_V) * real'(p1)) / 1024.0);
    n  = fitq(real'(-p2));
    return 16'(n);
  endfunction

  // One computation. mode 0: quiet; 1: random start/load_init/data noise while busy;
  // 2: start held one extra cycle after acceptance.
  task automatic do_op(input logic [15:0] d, input logic [15:0] a, input logic [15:0] exp, input int mode);
    delta_in  = d;
    act_in    = a;
    start     = 1'b1;
    load_init = 1'b0;
    tick;
    for (int c = 0; c < 3; c++) begin
      check("busy_during_op", busy, 16'd1);
      check("upd_during_op", select_update, 16'd0);
      check("init_during_op", select_initial, 16'd0);
      if (mode == 1) begin
        start     = 1'($urandom_range(0, 1));
        load_init = 1'($urandom_range(0, 1));
        delta_in  = 16'($urandom);
        act_in    = 16'($urandom);
      end else if (mode == 2 && c == 0) begin
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick;
    end
    start     = 1'b0;
    load_init = 1'b0;
    check("upd_pulse", select_update, 16'd1);
    check("dw_value", dw_out, exp);
    check("busy_done", busy, 16'd0);
    check("init_at_result", select_initial, 16'd0);
    tick;
    check("upd_one_cycle", select_update, 16'd0);
    check("dw_hold", dw_out, exp);
    check("init_after_op", select_initial, 16'd0);
    last_dw = exp;
  endtask

  initial begin
    logic [15:0] d;
    logic [15:0] a;

    reset = 1'b1; start = 1'b0; load_init = 1'b0;
    delta_in = '0; act_in = '0; last_dw = '0;
    #3;
    check("rst_dw", dw_out, 16'h0000);
    check("rst_upd", select_update, 16'd0);
    check("rst_init", select_initial, 16'd0);
    check("rst_busy", busy, 16'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // First start right after reset release, then the directed vectors.
    do_op(16'h0400, 16'h0200, 16'hFF00, 0);
    do_op(16'hFC00, 16'h0200, 16'h0100, 0);
`ifdef DW_SAT_EN
    do_op(16'h7C00, 16'h7C00, 16'hC001, 0);
`else
    do_op(16'h7C00, 16'h7C00, 16'hFE00, 0);
`endif
    do_op(16'h1234, 16'h0000, 16'h0000, 0);
    do_op(16'h0001, 16'hFFFF, 16'h0001, 0);

    // load_init and start together in IDLE: init strobe only.
    delta_in = 16'h0400; act_in = 16'h0400; start = 1'b1; load_init = 1'b1;
    tick;
    check("init_pulse", select_initial, 16'd1);
    check("init_no_busy", busy, 16'd0);
    check("init_no_upd", select_update, 16'd0);
    check("init_dw_kept", dw_out, last_dw);
    start = 1'b0; load_init = 1'b0;
    tick;
    check("init_end", select_initial, 16'd0);
    check("init_end_busy", busy, 16'd0);
    check("init_end_upd", select_update, 16'd0);
    check("init_end_dw", dw_out, last_dw);

    // Start re-asserted right after acceptance, then a normal start.
    do_op(16'h0800, 16'hFE00, model_dw(16'h0800, 16'hFE00), 2);
    do_op(16'h0C00, 16'h0300, model_dw(16'h0C00, 16'h0300), 0);

    // Start held high: one result every 4 cycles.
    start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      delta_in = 16'($urandom);
      act_in   = 16'($urandom);
      if (i % 4 == 0) exp_q.push_back(model_dw(delta_in, act_in));
      tick;
      if (i % 4 == 3) begin
        check("b2b_upd", select_update, 16'd1);
        last_dw = exp_q.pop_front();
        check("b2b_dw", dw_out, last_dw);
      end else begin
        check("b2b_no_upd", select_update, 16'd0);
      end
    end
    start = 1'b0;
    tick;

    // Randomized operations with mixed magnitudes and busy-time noise.
    for (int k = 0; k < 40; k++) begin
      d = 16'($urandom);
      a = 16'($urandom);
      if ($urandom_range(0, 1) == 1) d = {{5{d[10]}}, d[10:0]};
      if ($urandom_range(0, 1) == 1) a = {{5{a[10]}}, a[10:0]};
      do_op(d, a, model_dw(d, a), int'($urandom_range(0, 1)));
    end

    // Reset during MUL2 aborts the request.
    delta_in = 16'h0400; act_in = 16'h0200; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    #2 reset = 1'b1;
    #1;
    check("midrst_dw", dw_out, 16'h0000);
    check("midrst_upd", select_update, 16'd0);
    check("midrst_init", select_initial, 16'd0);
    check("midrst_busy", busy, 16'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    last_dw = '0;
    for (int i = 0; i < 6; i++) begin
      tick;
      check("abort_no_upd", select_update, 16'd0);
      check("abort_dw_zero", dw_out, 16'h0000);
    end
    do_op(16'hFC00, 16'h0200, 16'h0100, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
